uart_tx_fifo_drain: RTL and testbench

// - UART transmit engine on the read side of the async TX FIFO: pops bytes via the

---
 rtl/uart_tx_fifo_drain_pkg.sv | 22 ++
 rtl/uart_tx_fifo_drain_baud_cnt.sv | 28 ++
 rtl/uart_tx_fifo_drain.sv | 123 ++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared definitions for the UART transmit engine that drains the async TX FIFO.
// State encodings, default bit period and a frame-length helper.
package uart_tx_fifo_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } tx_state_e;

    // 100 MHz read clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    function automatic int frame_bits(input int width, input int parity_en, input int stop_bits);
        return 1 + width + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, held at 0 by clear.
// tick is high in the last cycle of each bit period.
module uart_tx_fifo_drain_baud_cnt #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter on the read side of the TX FIFO: pops one byte per frame and
// serialises it LSB first with optional parity and 1 or 2 stop bits.
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             tx_en,
    input  logic             empty,
    input  logic [WIDTH-1:0] rdata,
    output logic             rinc,
    output logic             tx,
    output logic             busy,
    output tx_state_e        state
);
    localparam int IDX_MAX = (WIDTH > STOP_BITS) ? WIDTH : STOP_BITS;
    localparam int BW      = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
    localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic ODD_BIT = (PARITY_ODD != 0);

    logic [WIDTH-1:0] shifter;
    logic [BW-1:0]    bit_idx;
    logic             par;
    logic             tick;
    logic             baud_clear;

    // The bit period starts counting on the edge that drives the start bit.
    assign baud_clear = (state == ST_IDLE) || (state == ST_POP) || (state == ST_LOAD);
    assign rinc       = (state == ST_POP);

    uart_tx_fifo_drain_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (rclk),
        .rst  (rrst),
        .clear(baud_clear),
        .tick (tick)
    );

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            shifter <= '0;
            par     <= 1'b0;
            bit_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tx_en && !empty) begin
                        state <= ST_POP;
                        busy  <= 1'b1;
                    end
                end
                ST_POP: state <= ST_LOAD;
                ST_LOAD: begin
                    // rdata was registered by the FIFO on the POP edge
                    shifter <= rdata;
                    par     <= (^rdata) ^ ODD_BIT;
                    bit_idx <= '0;
                    tx      <= 1'b0;
                    state   <= ST_START;
                end
                ST_START: begin
                    if (tick) begin
                        tx      <= shifter[0];
                        shifter <= shifter >> 1;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                tx    <= par;
                                state <= ST_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shifter[0];
                            shifter <= shifter >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            busy    <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: four instances (8N1, 8E1, 8O1, 8N2) at 4 clocks/bit,
// each fed by a small FIFO model, checked against hand-computed frames.
module tb_uart_tx_fifo_drain;
    import uart_tx_fifo_drain_pkg::*;

    localparam int CPB = 4;
    localparam int N   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] tx_en = '0;
    logic [N-1:0] empty;
    logic [N-1:0] rinc;
    logic [N-1:0] tx;
    logic [N-1:0] busy;
    logic [7:0]   rdata [N] = '{default: 8'h00};
    tx_state_e    st [N];

    logic [7:0] fmem [N][16];
    logic [3:0] rd_ptr [N] = '{default: 4'd0};
    logic [3:0] wr_ptr [N] = '{default: 4'd0};
    int rinc_cnt [N] = '{default: 0};
    int pop_err = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_tx_fifo_drain #(
            .WIDTH       (8),
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   ((g == 1 || g == 2) ? 1 : 0),
            .PARITY_ODD  ((g == 2) ? 1 : 0),
            .STOP_BITS   ((g == 3) ? 2 : 1)
        ) u_dut (
            .rclk (clk),
            .rrst (rst),
            .tx_en(tx_en[g]),
            .empty(empty[g]),
            .rdata(rdata[g]),
            .rinc (rinc[g]),
            .tx   (tx[g]),
            .busy (busy[g]),
            .state(st[g])
        );
        assign empty[g] = (rd_ptr[g] == wr_ptr[g]);
    end

    // FIFO read-port model: rdata registered on the edge where rinc=1 and empty=0
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rinc[i]) begin
                rinc_cnt[i] <= rinc_cnt[i] + 1;
                if (empty[i]) begin
                    pop_err <= pop_err + 1;
                end else begin
                    rdata[i]  <= fmem[i][rd_ptr[i]];
                    rd_ptr[i] <= rd_ptr[i] + 4'd1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        fmem[i][wr_ptr[i]] = b;
        wr_ptr[i] = wr_ptr[i] + 4'd1;
    endtask

    // Waits for the start bit, then samples every cycle of nbits bit periods.
    // wait_n = high cycles seen before the start bit; bad counts unstable bits / busy low.
    task automatic capture(input int i, input int nbits, input int drop_at,
                           output logic [11:0] bits, output int wait_n, output int bad);
        int k;
        bits = '0;
        wait_n = 0;
        bad = 0;
        k = 0;
        @(negedge clk);
        while (tx[i] !== 1'b0 && wait_n < 100) begin
            wait_n++;
            @(negedge clk);
        end
        if (tx[i] !== 1'b0) begin
            bad = 999;
            return;
        end
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (k > 0) @(negedge clk);
                if (k == drop_at) tx_en[i] = 1'b0;
                if (c == 0) bits[b] = tx[i];
                else if (tx[i] !== bits[b]) bad++;
                if (busy[i] !== 1'b1) bad++;
                k++;
            end
        end
    endtask

    task automatic idle_watch(input int i, input int n, output int lows);
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx[i] !== 1'b1) lows++;
        end
    endtask

    typedef struct {
        int          inst;
        logic [7:0]  data;
        logic [11:0] frame;
        int          nbits;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [11:0] bits;
        int w, bad, r0, lows, i;

        // frame bit k is the k-th bit on the line: start, data LSB first, [parity], stop(s)
        vecs[0] = '{0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10};
        vecs[1] = '{0, 8'h3C, {2'b00, 1'b1, 8'h3C, 1'b0}, 10};
        vecs[2] = '{1, 8'h07, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11};
        vecs[3] = '{2, 8'h07, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11};
        vecs[4] = '{1, 8'h00, {1'b0, 1'b1, 1'b0, 8'h00, 1'b0}, 11};
        vecs[5] = '{3, 8'h5A, {1'b0, 1'b1, 1'b1, 8'h5A, 1'b0}, 11};
        vecs[6] = '{2, 8'hFF, {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 11};

        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("reset_tx", int'(tx[k]), 1);
            check("reset_rinc", int'(rinc[k]), 0);
            check("reset_busy", int'(busy[k]), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("idle_state", int'(st[0]), int'(ST_IDLE));

        for (int v = 0; v < 7; v++) begin
            i = vecs[v].inst;
            r0 = rinc_cnt[i];
            tx_en[i] = 1'b1;
            push(i, vecs[v].data);
            capture(i, vecs[v].nbits, -1, bits, w, bad);
            check($sformatf("vec%0d_frame", v), int'(bits), int'(vecs[v].frame));
            check($sformatf("vec%0d_latency", v), w, 2);
            check($sformatf("vec%0d_timing", v), bad, 0);
            @(negedge clk);
            check($sformatf("vec%0d_rinc", v), rinc_cnt[i] - r0, 1);
            check($sformatf("vec%0d_busy_end", v), int'(busy[i]), 0);
            check($sformatf("vec%0d_state_end", v), int'(st[i]), int'(ST_IDLE));
            tx_en[i] = 1'b0;
        end

        // back-to-back 0x00, 0xFF on 8N1
        r0 = rinc_cnt[0];
        tx_en[0] = 1'b1;
        push(0, 8'h00);
        push(0, 8'hFF);
        capture(0, 10, -1, bits, w, bad);
        check("b2b_frame0", int'(bits), int'({2'b00, 1'b1, 8'h00, 1'b0}));
        check("b2b_timing0", bad, 0);
        capture(0, 10, -1, bits, w, bad);
        check("b2b_frame1", int'(bits), int'({2'b00, 1'b1, 8'hFF, 1'b0}));
        check("b2b_gap", w, 3);
        check("b2b_timing1", bad, 0);
        idle_watch(0, 20, lows);
        check("b2b_idle_low", lows, 0);
        check("b2b_rinc", rinc_cnt[0] - r0, 2);
        tx_en[0] = 1'b0;

        // back-to-back with two stop bits
        r0 = rinc_cnt[3];
        tx_en[3] = 1'b1;
        push(3, 8'h11);
        push(3, 8'h22);
        capture(3, 11, -1, bits, w, bad);
        check("stop2_frame0", int'(bits), int'({1'b0, 1'b1, 1'b1, 8'h11, 1'b0}));
        check("stop2_timing0", bad, 0);
        capture(3, 11, -1, bits, w, bad);
        check("stop2_frame1", int'(bits), int'({1'b0, 1'b1, 1'b1, 8'h22, 1'b0}));
        check("stop2_gap", w, 3);
        check("stop2_timing1", bad, 0);
        @(negedge clk);
        check("stop2_rinc", rinc_cnt[3] - r0, 2);
        tx_en[3] = 1'b0;

        // tx_en dropped during data bit 3: frame completes, queued byte stays put
        r0 = rinc_cnt[0];
        tx_en[0] = 1'b1;
        push(0, 8'h3C);
        push(0, 8'h55);
        capture(0, 10, 4 + 3 * CPB + 1, bits, w, bad);
        check("drop_frame", int'(bits), int'({2'b00, 1'b1, 8'h3C, 1'b0}));
        check("drop_timing", bad, 0);
        idle_watch(0, 30, lows);
        check("drop_idle_low", lows, 0);
        check("drop_rinc", rinc_cnt[0] - r0, 1);
        check("drop_busy", int'(busy[0]), 0);
        tx_en[0] = 1'b1;
        capture(0, 10, -1, bits, w, bad);
        check("reenable_frame", int'(bits), int'({2'b00, 1'b1, 8'h55, 1'b0}));
        check("reenable_latency", w, 2);
        @(negedge clk);
        check("reenable_rinc", rinc_cnt[0] - r0, 2);

        // asynchronous reset in the middle of the data bits
        r0 = rinc_cnt[0];
        push(0, 8'hA5);
        capture(0, 3, -1, bits, w, bad);
        check("rst_partial_bits", int'(bits[2:0]), 2);
        check("rst_partial_tx", int'(tx[0]), 0);
        rst = 1'b1;
        #1;
        check("rst_async_tx", int'(tx[0]), 1);
        check("rst_async_rinc", int'(rinc[0]), 0);
        check("rst_async_busy", int'(busy[0]), 0);
        check("rst_async_state", int'(st[0]), int'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        idle_watch(0, 20, lows);
        check("rst_idle_low", lows, 0);
        check("rst_no_pop", rinc_cnt[0] - r0, 1);
        push(0, 8'h81);
        capture(0, 10, -1, bits, w, bad);
        check("rst_recover_frame", int'(bits), int'({2'b00, 1'b1, 8'h81, 1'b0}));
        check("rst_recover_latency", w, 2);
        check("rst_recover_timing", bad, 0);
        tx_en[0] = 1'b0;
        repeat (2) @(negedge clk);

        check("pop_while_empty", pop_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
